// File: rtl/and_reduce_sched.sv
// and_reduce_sched: round-robin scheduler that shares a single 2-input AND
// gate between two requesters and AND-reduces a WIDTH-bit vector serially,
// one bit per cycle.
//
// Handshake: reqN is held high with vecN valid until the block answers with a
// one-cycle gntN pulse. gntN means vecN was captured on that edge. The
// requester drops reqN in the gnt cycle; a req still high at the next IDLE
// edge counts as a new request. Requests seen outside IDLE are ignored, not
// queued. done pulses for one cycle when result/result_id are updated. Both
// outputs then hold until the next done.

module and2_gate (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

module and_reduce_sched #(
   parameter int WIDTH      = 4,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] vec0,
   input  logic             req1,
   input  logic [WIDTH-1:0] vec1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             result,
   output logic             result_id,
   output logic [1:0]       dbg_state
);

   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             acc_q, acc_d;
   logic             last_id_q, last_id_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             result_q, result_d;
   logic             result_id_q, result_id_d;

   logic             pick1;
   logic [WIDTH-1:0] cap_vec;
   logic             and_y;

   // The one shared gate: accumulator ANDed with the next unconsumed bit,
   // which always sits at bit 0 of the shift register.
   and2_gate u_and2 (
      .a (acc_q),
      .b (sreg_q[0]),
      .y (and_y)
   );

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         idx_q       <= '0;
         acc_q       <= 1'b0;
         last_id_q   <= 1'b1;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         result_q    <= 1'b0;
         result_id_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         last_id_q   <= last_id_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         result_q    <= result_d;
         result_id_q <= result_id_d;
      end
   end

   // Arbitration, serial evaluation and next-state/output decode.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      last_id_d   = last_id_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      done_d      = 1'b0;
      result_d    = result_q;
      result_id_d = result_id_q;

      // Requester 1 wins when alone, or on a tie when 0 was served last.
      pick1   = req1 & (~req0 | ~last_id_q);
      cap_vec = pick1 ? vec1 : vec0;

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               acc_d     = cap_vec[0];
               sreg_d    = cap_vec >> 1;
               idx_d     = IW'(1);
               last_id_d = pick1;
               gnt0_d    = ~pick1;
               gnt1_d    = pick1;
               state_d   = EVAL;
            end
         end
         EVAL: begin
            if (EARLY_EXIT && !acc_q) begin
               // A zero accumulator can never recover; finish now.
               result_d    = 1'b0;
               result_id_d = last_id_q;
               done_d      = 1'b1;
               state_d     = DONE;
            end else begin
               acc_d  = and_y;
               sreg_d = sreg_q >> 1;
               idx_d  = idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
                  result_d    = and_y;
                  result_id_d = last_id_q;
                  done_d      = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign result_id = result_id_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_and_reduce_sched.sv
// Bench for and_reduce_sched: one instance with EARLY_EXIT=0 (index 0) and one
// with EARLY_EXIT=1 (index 1), each with its own requesters and a
// transaction-level model predicting grant id, grant/done cycle, busy window
// and result for every cycle.

module tb_and_reduce_sched;

   localparam int W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [1:0]   rq0, rq1, g0, g1, bz, dn, rs, ri;
   logic [W-1:0] vv0 [2];
   logic [W-1:0] vv1 [2];
   logic [1:0]   st_a, st_b;

   and_reduce_sched #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req0(rq0[0]), .vec0(vv0[0]), .req1(rq1[0]), .vec1(vv1[0]),
      .gnt0(g0[0]), .gnt1(g1[0]), .busy(bz[0]), .done(dn[0]),
      .result(rs[0]), .result_id(ri[0]), .dbg_state(st_a)
   );

   and_reduce_sched #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req0(rq0[1]), .vec0(vv0[1]), .req1(rq1[1]), .vec1(vv1[1]),
      .gnt0(g0[1]), .gnt1(g1[1]), .busy(bz[1]), .done(dn[1]),
      .result(rs[1]), .result_id(ri[1]), .dbg_state(st_b)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_id [2];
   int free_at [2];
   int g_cyc [2];
   int d_cyc [2];
   int g_id [2];
   logic exp_res [2];
   logic exp_rid [2];
   logic [1:0] exp_q0 [$];   // {id, result} for the EARLY_EXIT=0 instance
   logic [1:0] exp_q1 [$];   // {id, result} for the EARLY_EXIT=1 instance
   bit rand_mode = 1'b0;
   bit hold_mode = 1'b0;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b exp %b (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Cycles from grant to done: WIDTH-1 normally; with early exit the
   // evaluation stops one edge after the accumulator first becomes zero.
   function automatic int latency(input logic [W-1:0] v, input bit ee);
      int l;
      bit found;
      l = W - 1;
      found = 1'b0;
      if (ee) begin
         for (int i = 0; i < W; i++) begin
            if (!found && v[i] == 1'b0) begin
               found = 1'b1;
               if (i + 1 < l) l = i + 1;
            end
         end
      end
      return l;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      if ($urandom_range(0, 1) == 0) v = '1;
      else v = W'($urandom);
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last_id[k] = 1;
         free_at[k] = cyc + 1;
         g_cyc[k]   = -1;
         d_cyc[k]   = -1;
         g_id[k]    = 0;
         exp_res[k] = 1'b0;
         exp_rid[k] = 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
   endtask

   // Decide what the coming edge does, from the request values now driven.
   task automatic predict(input int k);
      int n1, id, l;
      logic [W-1:0] v;
      logic all1;
      n1 = cyc + 1;
      if (n1 >= free_at[k] && (rq0[k] || rq1[k])) begin
         if (rq0[k] && rq1[k]) id = 1 - last_id[k];
         else id = rq0[k] ? 0 : 1;
         v = (id == 1) ? vv1[k] : vv0[k];
         l = latency(v, k == 1);
         all1 = (v == {W{1'b1}});
         g_cyc[k]   = n1;
         g_id[k]    = id;
         d_cyc[k]   = n1 + l;
         free_at[k] = n1 + l + 2;
         last_id[k] = id;
         if (k == 0) exp_q0.push_back({id == 1, all1});
         else exp_q1.push_back({id == 1, all1});
      end
   endtask

   task automatic check_cycle(input int k);
      logic [1:0] e;
      bit in_job;
      if (cyc == d_cyc[k]) begin
         if (k == 0) e = exp_q0.pop_front();
         else e = exp_q1.pop_front();
         exp_rid[k] = e[1];
         exp_res[k] = e[0];
      end
      in_job = (g_cyc[k] >= 0) && (cyc >= g_cyc[k]) && (cyc <= d_cyc[k]);
      check($sformatf("d%0d_gnt0", k), g0[k], (cyc == g_cyc[k]) && (g_id[k] == 0));
      check($sformatf("d%0d_gnt1", k), g1[k], (cyc == g_cyc[k]) && (g_id[k] == 1));
      check($sformatf("d%0d_done", k), dn[k], cyc == d_cyc[k]);
      check($sformatf("d%0d_busy", k), bz[k], in_job);
      check($sformatf("d%0d_result", k), rs[k], exp_res[k]);
      check($sformatf("d%0d_result_id", k), ri[k], exp_rid[k]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic req_update(input int k);
      bit gr0, gr1;
      gr0 = (cyc == g_cyc[k]) && (g_id[k] == 0);
      gr1 = (cyc == g_cyc[k]) && (g_id[k] == 1);
      if (gr0 && (!hold_mode || rand_mode)) rq0[k] = 1'b0;
      else if (rand_mode) begin
         if (!rq0[k]) begin
            if ($urandom_range(0, 2) == 0) begin
               vv0[k] = rand_vec();
               rq0[k] = 1'b1;
            end
         end else if ($urandom_range(0, 15) == 0) rq0[k] = 1'b0;
      end
      if (gr1 && (!hold_mode || rand_mode)) rq1[k] = 1'b0;
      else if (rand_mode) begin
         if (!rq1[k]) begin
            if ($urandom_range(0, 2) == 0) begin
               vv1[k] = rand_vec();
               rq1[k] = 1'b1;
            end
         end else if ($urandom_range(0, 15) == 0) rq1[k] = 1'b0;
      end
   endtask

   task automatic step();
      predict(0);
      predict(1);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle(0);
      check_cycle(1);
      req_update(0);
      req_update(1);
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_d%0d_gnt0", tag, k), g0[k], 1'b0);
         check($sformatf("%s_d%0d_gnt1", tag, k), g1[k], 1'b0);
         check($sformatf("%s_d%0d_done", tag, k), dn[k], 1'b0);
         check($sformatf("%s_d%0d_busy", tag, k), bz[k], 1'b0);
         check($sformatf("%s_d%0d_result", tag, k), rs[k], 1'b0);
         check($sformatf("%s_d%0d_result_id", tag, k), ri[k], 1'b0);
      end
   endtask

   task automatic set_vecs(input logic [W-1:0] a, input logic [W-1:0] b);
      vv0[0] = a; vv0[1] = a;
      vv1[0] = b; vv1[1] = b;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      rq0 = 2'b00;
      rq1 = 2'b00;
      set_vecs('0, '0);
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      model_reset();
      rst_n = 1'b1;

      // Single requester 0, all ones: gnt cycle 1, done cycle 4, result 1.
      set_vecs(4'b1111, '0);
      rq0 = 2'b11;
      repeat (7) step();

      // Single requester 1 with a zero bit.
      set_vecs('0, 4'b1011);
      rq1 = 2'b11;
      repeat (7) step();

      // Both held continuously: alternating grants 5 cycles apart.
      hold_mode = 1'b1;
      set_vecs(4'b1111, 4'b1110);
      rq0 = 2'b11;
      rq1 = 2'b11;
      repeat (16) step();
      rq0 = 2'b00;
      rq1 = 2'b00;
      hold_mode = 1'b0;
      repeat (7) step();

      // Early exit on low zero bits, and a zero only in the top bit.
      set_vecs(4'b1100, '0);
      rq0 = 2'b11;
      repeat (7) step();
      set_vecs(4'b0111, '0);
      rq0 = 2'b11;
      repeat (7) step();

      // One-cycle req1 pulse while busy is ignored.
      set_vecs(4'b1111, 4'b1010);
      rq0 = 2'b11;
      step();
      step();
      rq1 = 2'b11;
      step();
      rq1 = 2'b00;
      repeat (7) step();

      // Asynchronous reset in the middle of evaluation.
      set_vecs(4'b1111, '0);
      rq0 = 2'b11;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      rq0 = 2'b00;
      rq1 = 2'b00;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      set_vecs(4'b1111, 4'b1101);
      rq0 = 2'b11;
      rq1 = 2'b11;
      repeat (14) step();

      // Randomized traffic.
      rand_mode = 1'b1;
      repeat (600) step();
      rand_mode = 1'b0;
      rq0 = 2'b00;
      rq1 = 2'b00;
      repeat (8) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
